// File: rtl/dma_master_pkg.sv
// Shared definitions for the DMA master block.
// Holds the bus width, the zero word, the config-register offsets
// (decoded from address bits [3:0]), the CTRL bit indices, the address
// step, and the FSM state encoding. There are no ports.
package dma_master_pkg;

  localparam int BUS_W = 32;
  localparam int OFF_W = 4;

  localparam logic [BUS_W-1:0] ZERO_WORD = '0;
  localparam logic [BUS_W-1:0] ADDR_STEP = 32'd4;

  localparam logic [OFF_W-1:0] OFF_CTRL = 4'h0;
  localparam logic [OFF_W-1:0] OFF_SRC  = 4'h4;
  localparam logic [OFF_W-1:0] OFF_DST  = 4'h8;
  localparam logic [OFF_W-1:0] OFF_LEN  = 4'hC;

  localparam int CTRL_BUSY = 0;
  localparam int CTRL_IE   = 1;
  localparam int CTRL_DONE = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } dma_state_e;

endpackage

// File: rtl/dma_regs.sv
// Config register file for the DMA master: CTRL, SRC, DST and LEN, plus
// the registered-address read mux.
// Ports:
//   clk, rst_n            clock and async active-low reset
//   wr_en_i/wr_addr_i/wr_data_i  config write port (offset in bits [3:0])
//   rd_addr_i, rd_data_o  config read port, one-cycle latency
//   done_set_i            pulse from the FSM DONE state
//   ctrl_wr_o             a CTRL write is being presented this cycle
//   src_o, dst_o, len_o   programmed transfer parameters
//   int_flag_o            CTRL[2] AND CTRL[1]
module dma_regs
  import dma_master_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [BUS_W-1:0] wr_addr_i,
  input  logic [BUS_W-1:0] wr_data_i,
  input  logic [BUS_W-1:0] rd_addr_i,
  output logic [BUS_W-1:0] rd_data_o,
  input  logic             done_set_i,
  output logic             ctrl_wr_o,
  output logic [BUS_W-1:0] src_o,
  output logic [BUS_W-1:0] dst_o,
  output logic [BUS_W-1:0] len_o,
  output logic             int_flag_o
);

  logic [2:0]       ctrl_q;
  logic [BUS_W-1:0] src_q, dst_q, len_q;
  logic [OFF_W-1:0] rd_off_q;
  logic [OFF_W-1:0] wr_off;
  logic             unused_addr_bits;

  assign wr_off           = wr_addr_i[OFF_W-1:0];
  assign ctrl_wr_o        = wr_en_i && (wr_off == OFF_CTRL);
  assign unused_addr_bits = ^{wr_addr_i[BUS_W-1:OFF_W], rd_addr_i[BUS_W-1:OFF_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= 3'b000;
      src_q    <= ZERO_WORD;
      dst_q    <= ZERO_WORD;
      len_q    <= ZERO_WORD;
      rd_off_q <= '0;
    end else begin
      rd_off_q <= rd_addr_i[OFF_W-1:0];
      // DONE wins over a simultaneous software write: done bit set, busy cleared.
      if (done_set_i) begin
        ctrl_q[CTRL_BUSY] <= 1'b0;
        ctrl_q[CTRL_DONE] <= 1'b1;
        if (ctrl_wr_o)
          ctrl_q[CTRL_IE] <= wr_data_i[CTRL_IE];
      end else if (ctrl_wr_o) begin
        ctrl_q[CTRL_BUSY] <= wr_data_i[CTRL_BUSY];
        ctrl_q[CTRL_IE]   <= wr_data_i[CTRL_IE];
        // Software can only clear the done-pending bit.
        ctrl_q[CTRL_DONE] <= ctrl_q[CTRL_DONE] & wr_data_i[CTRL_DONE];
      end
      // Transfer parameters are frozen while a transfer is running.
      if (wr_en_i && !ctrl_q[CTRL_BUSY]) begin
        case (wr_off)
          OFF_SRC: src_q <= wr_data_i;
          OFF_DST: dst_q <= wr_data_i;
          OFF_LEN: len_q <= wr_data_i;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_data_o = ZERO_WORD;
    case (rd_off_q)
      OFF_CTRL: rd_data_o = {29'd0, ctrl_q};
      OFF_SRC:  rd_data_o = src_q;
      OFF_DST:  rd_data_o = dst_q;
      OFF_LEN:  rd_data_o = len_q;
      default:  rd_data_o = ZERO_WORD;
    endcase
  end

  assign src_o      = src_q;
  assign dst_o      = dst_q;
  assign len_o      = len_q;
  assign int_flag_o = ctrl_q[CTRL_DONE] & ctrl_q[CTRL_IE];

endmodule

// File: rtl/dma_master.sv
// Single-channel memory-to-memory DMA master.
// Software programs SRC/DST/LEN and sets CTRL[0]; the block arbitrates for
// the bus and copies LEN words, one read cycle then one write cycle each.
// Ports:
//   clk, rst_n                       clock and async active-low reset
//   wr_en_i, wr_addr_i, wr_data_i    config write port
//   rd_addr_i, rd_data_o             config read port (one-cycle latency)
//   m_req_o, m_gnt_i                 arbiter handshake
//   m_rd_addr_o, m_rd_data_i         master read (data valid next cycle)
//   m_wr_en_o, m_wr_addr_o, m_wr_data_o  master write
//   dma_int_flag_o                   done-pending AND interrupt enable
module dma_master
  import dma_master_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic [31:0] rd_addr_i,
  output logic [31:0] rd_data_o,
  output logic        m_req_o,
  input  logic        m_gnt_i,
  output logic [31:0] m_rd_addr_o,
  input  logic [31:0] m_rd_data_i,
  output logic        m_wr_en_o,
  output logic [31:0] m_wr_addr_o,
  output logic [31:0] m_wr_data_o,
  output logic        dma_int_flag_o
);

  dma_state_e       state_q, state_d;
  logic [BUS_W-1:0] src_cur, dst_cur, cnt_cur;
  logic [BUS_W-1:0] src_reg, dst_reg, len_reg;
  logic             ctrl_wr, done_set, start, abort;

  dma_regs u_regs (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o),
    .done_set_i (done_set),
    .ctrl_wr_o  (ctrl_wr),
    .src_o      (src_reg),
    .dst_o      (dst_reg),
    .len_o      (len_reg),
    .int_flag_o (dma_int_flag_o)
  );

  // Start is taken from the write strobe itself so the FSM leaves IDLE on
  // the cycle after the write; abort is any CTRL write with bit 0 low.
  assign start = ctrl_wr &&  wr_data_i[CTRL_BUSY] && (state_q == ST_IDLE);
  assign abort = ctrl_wr && !wr_data_i[CTRL_BUSY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      src_cur <= ZERO_WORD;
      dst_cur <= ZERO_WORD;
      cnt_cur <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      if (start) begin
        src_cur <= src_reg;
        dst_cur <= dst_reg;
        cnt_cur <= len_reg;
      end else if (state_q == ST_WR) begin
        src_cur <= src_cur + ADDR_STEP;
        dst_cur <= dst_cur + ADDR_STEP;
        cnt_cur <= cnt_cur - 32'd1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    done_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start)
          state_d = (len_reg == ZERO_WORD) ? ST_DONE : ST_ARB;
      end
      ST_ARB: begin
        if (abort)
          state_d = ST_IDLE;
        else if (m_gnt_i)
          state_d = ST_RD;
      end
      ST_RD: begin
        state_d = abort ? ST_IDLE : ST_WR;
      end
      ST_WR: begin
        // The word written this cycle completes even when aborting.
        if (abort)
          state_d = ST_IDLE;
        else if (cnt_cur == 32'd1)
          state_d = ST_DONE;
        else if (m_gnt_i)
          state_d = ST_RD;
        else
          state_d = ST_ARB;
      end
      ST_DONE: begin
        done_set = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign m_req_o     = (state_q == ST_ARB) || (state_q == ST_RD) || (state_q == ST_WR);
  assign m_rd_addr_o = (state_q == ST_RD) ? src_cur : ZERO_WORD;
  assign m_wr_en_o   = (state_q == ST_WR);
  assign m_wr_addr_o = (state_q == ST_WR) ? dst_cur : ZERO_WORD;
  assign m_wr_data_o = (state_q == ST_WR) ? m_rd_data_i : ZERO_WORD;

endmodule

// File: tb/tb_dma_master.sv
// Self-checking bench for dma_master: register table, directed transfer
// sequences and randomized transfers checked against a list-of-writes model.
module tb_dma_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en_i;
  logic [31:0] wr_addr_i, wr_data_i, rd_addr_i, rd_data_o;
  logic        m_req_o, m_gnt_i, m_wr_en_o, dma_int_flag_o;
  logic [31:0] m_rd_addr_o, m_rd_data_i, m_wr_addr_o, m_wr_data_o;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic [31:0] wq_raddr[$];
  int          wq_cyc[$];
  logic [31:0] rd_addr_seen;

  dma_master dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_en_i        (wr_en_i),
    .wr_addr_i      (wr_addr_i),
    .wr_data_i      (wr_data_i),
    .rd_addr_i      (rd_addr_i),
    .rd_data_o      (rd_data_o),
    .m_req_o        (m_req_o),
    .m_gnt_i        (m_gnt_i),
    .m_rd_addr_o    (m_rd_addr_o),
    .m_rd_data_i    (m_rd_data_i),
    .m_wr_en_o      (m_wr_en_o),
    .m_wr_addr_o    (m_wr_addr_o),
    .m_wr_data_o    (m_wr_data_o),
    .dma_int_flag_o (dma_int_flag_o)
  );

  always #5 clk = ~clk;

  // Source memory contents as a function of address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + 32'h0000_1357;
  endfunction

  // Memory answers the cycle after the read address is presented.
  always @(posedge clk) begin
    cyc          <= cyc + 1;
    rd_addr_seen <= m_rd_addr_o;
  end
  assign m_rd_data_i = mem_word(rd_addr_seen);

  always @(negedge clk) begin
    if (m_wr_en_o) begin
      wq_addr.push_back(m_wr_addr_o);
      wq_data.push_back(m_wr_data_o);
      wq_raddr.push_back(rd_addr_seen);
      wq_cyc.push_back(cyc);
    end
  end

  typedef struct {
    bit          do_wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [31:0] a, input logic [31:0] d);
    wr_en_i   = 1'b1;
    wr_addr_i = a;
    wr_data_i = d;
    tick();
    wr_en_i   = 1'b0;
    wr_addr_i = 32'h0;
    wr_data_i = 32'h0;
  endtask

  task automatic cfg_read(input logic [31:0] a, output logic [31:0] d);
    rd_addr_i = a;
    tick();
    d = rd_data_o;
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    wq_raddr.delete();
    wq_cyc.delete();
  endtask

  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d,
                            input logic [31:0] n, input logic [31:0] c);
    cfg_write(32'h4, s);
    cfg_write(32'h8, d);
    cfg_write(32'hC, n);
    clear_log();
    cfg_write(32'h0, c);
  endtask

  // Polls CTRL until busy clears; optionally randomizes grant each cycle.
  task automatic wait_idle(input string name, input int maxc, input bit rnd_gnt);
    logic [31:0] d;
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (rnd_gnt) m_gnt_i = 1'($urandom_range(0, 1));
      cfg_read(32'h0, d);
      if (!d[0]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL %s: busy still set after %0d cycles, required idle", name, maxc);
    end
  endtask

  // Returns on the cycle in which the n-th write strobe is visible.
  task automatic wait_writes(input string name, input int n, input int maxc);
    int seen = 0;
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (m_wr_en_o) seen++;
      if (seen == n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL %s: saw %0d write strobes, required %0d", name, seen, n);
    end
  endtask

  // Reference: word i goes to dst+4i with the data stored at src+4i.
  task automatic check_writes(input string name, input logic [31:0] s,
                              input logic [31:0] d, input int n);
    check({name, "_count"}, 32'(wq_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wq_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", name, i), wq_addr[i], d + 32'(4 * i));
      check($sformatf("%s_data%0d", name, i), wq_data[i], mem_word(s + 32'(4 * i)));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, s, ds, n;
    bit ie;
    int base;

    rst_n     = 1'b0;
    wr_en_i   = 1'b0;
    wr_addr_i = 32'h0;
    wr_data_i = 32'h0;
    rd_addr_i = 32'h0;
    m_gnt_i   = 1'b0;

    vecs[0]  = '{1'b0, 32'h0,  32'h0,        32'h0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0,  32'h0,        32'h4, 32'h0};
    vecs[2]  = '{1'b0, 32'h0,  32'h0,        32'h8, 32'h0};
    vecs[3]  = '{1'b0, 32'h0,  32'h0,        32'hC, 32'h0};
    vecs[4]  = '{1'b1, 32'h4,  32'h11223344, 32'h4, 32'h11223344};
    vecs[5]  = '{1'b1, 32'h8,  32'hCAFEF00C, 32'h8, 32'hCAFEF00C};
    vecs[6]  = '{1'b1, 32'hC,  32'h7,        32'hC, 32'h7};
    vecs[7]  = '{1'b1, 32'h6,  32'hFFFFFFFF, 32'h6, 32'h0};
    vecs[8]  = '{1'b1, 32'h1,  32'h123,      32'h4, 32'h11223344};
    vecs[9]  = '{1'b1, 32'h0,  32'hFFFFFFFA, 32'h0, 32'h2};
    vecs[10] = '{1'b1, 32'h14, 32'h55AA55A8, 32'h4, 32'h55AA55A8};
    vecs[11] = '{1'b1, 32'h0,  32'h0,        32'h0, 32'h0};
    vecs[12] = '{1'b1, 32'hE,  32'h1,        32'hE, 32'h0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(m_req_o), 32'h0);
    check("rst_wr_en", 32'(m_wr_en_o), 32'h0);
    check("rst_rd_data", rd_data_o, 32'h0);
    check("rst_int", 32'(dma_int_flag_o), 32'h0);
    rst_n = 1'b1;
    tick();

    // Register table
    foreach (vecs[i]) begin
      if (vecs[i].do_wr) cfg_write(vecs[i].waddr, vecs[i].wdata);
      cfg_read(vecs[i].raddr, d);
      check($sformatf("regvec%0d", i), d, vecs[i].exp);
    end
    // Read data follows the registered address, not the live one.
    cfg_read(32'h4, d);
    rd_addr_i = 32'h8;
    #1;
    check("rd_latency", rd_data_o, 32'h55AA55A8);

    // Three-word transfer, grant tied high
    m_gnt_i = 1'b1;
    start_xfer(32'h100, 32'h200, 32'd3, 32'h3);
    wait_idle("basic_wait", 50, 1'b0);
    check_writes("basic", 32'h100, 32'h200, 3);
    if (wq_cyc.size() == 3) begin
      check("basic_gap1", 32'(wq_cyc[1] - wq_cyc[0]), 32'd2);
      check("basic_gap2", 32'(wq_cyc[2] - wq_cyc[1]), 32'd2);
    end
    cfg_read(32'h0, d);
    check("basic_ctrl", d, 32'h6);
    check("basic_int", 32'(dma_int_flag_o), 32'h1);

    // Done-pending clear semantics
    cfg_write(32'h0, 32'h6);
    cfg_read(32'h0, d);
    check("w1_keeps_done", d, 32'h6);
    cfg_write(32'h0, 32'h2);
    check("int_drop", 32'(dma_int_flag_o), 32'h0);
    cfg_read(32'h0, d);
    check("clear_done", d, 32'h2);
    cfg_write(32'h0, 32'h4);
    cfg_read(32'h0, d);
    check("no_set_by_sw", d, 32'h0);

    // Zero-length transfer
    cfg_write(32'hC, 32'h0);
    clear_log();
    cfg_write(32'h0, 32'h3);
    check("len0_int_early", 32'(dma_int_flag_o), 32'h0);
    cfg_read(32'h0, d);
    check("len0_ctrl", d, 32'h6);
    repeat (3) begin
      tick();
      check("len0_req", 32'(m_req_o), 32'h0);
    end
    check("len0_writes", 32'(wq_addr.size()), 32'h0);
    cfg_write(32'h0, 32'h0);

    // CTRL write landing in the DONE cycle
    cfg_write(32'h0, 32'h3);
    cfg_write(32'h0, 32'h3);
    cfg_read(32'h0, d);
    check("done_prio_ctrl", d, 32'h6);
    check("done_prio_req", 32'(m_req_o), 32'h0);
    cfg_write(32'h0, 32'h0);

    // Grant withdrawn for 5 cycles after the second word
    m_gnt_i = 1'b1;
    start_xfer(32'h300, 32'h400, 32'd4, 32'h1);
    wait_writes("stall_w2", 2, 20);
    m_gnt_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) cfg_write(32'h4, 32'hDEAD0000);
      else tick();
      check($sformatf("stall_req%0d", i), 32'(m_req_o), 32'h1);
      check($sformatf("stall_wr%0d", i), 32'(m_wr_en_o), 32'h0);
      check($sformatf("stall_rd%0d", i), m_rd_addr_o, 32'h0);
    end
    m_gnt_i = 1'b1;
    wait_idle("stall_wait", 50, 1'b0);
    check_writes("stall", 32'h300, 32'h400, 4);
    if (wq_cyc.size() == 4) check("stall_gap", 32'(wq_cyc[2] - wq_cyc[1]), 32'd7);
    cfg_read(32'h4, d);
    check("busy_src_locked", d, 32'h300);
    cfg_read(32'h0, d);
    check("stall_ctrl", d, 32'h4);
    check("stall_int", 32'(dma_int_flag_o), 32'h0);
    cfg_write(32'h0, 32'h0);

    // Source address wrap
    start_xfer(32'hFFFFFFFC, 32'h500, 32'd2, 32'h1);
    wait_idle("wrap_wait", 50, 1'b0);
    check_writes("wrap", 32'hFFFFFFFC, 32'h500, 2);
    if (wq_raddr.size() == 2) check("wrap_raddr", wq_raddr[1], 32'h0);
    cfg_write(32'h0, 32'h0);

    // Abort during word 2 of 4
    start_xfer(32'h600, 32'h700, 32'd4, 32'h1);
    wait_writes("abort_w2", 2, 20);
    cfg_write(32'h0, 32'h0);
    repeat (6) tick();
    check_writes("abort_wr", 32'h600, 32'h700, 2);
    cfg_read(32'h0, d);
    check("abort_ctrl", d, 32'h0);
    check("abort_req", 32'(m_req_o), 32'h0);

    // Abort while waiting for grant, then a fresh transfer
    m_gnt_i = 1'b0;
    start_xfer(32'h800, 32'h900, 32'd3, 32'h1);
    tick();
    cfg_write(32'h0, 32'h0);
    m_gnt_i = 1'b1;
    repeat (4) tick();
    check("abort_arb_writes", 32'(wq_addr.size()), 32'h0);
    check("abort_arb_req", 32'(m_req_o), 32'h0);
    start_xfer(32'h800, 32'h900, 32'd1, 32'h1);
    wait_idle("restart_wait", 50, 1'b0);
    check_writes("restart", 32'h800, 32'h900, 1);
    cfg_write(32'h0, 32'h0);

    // Randomized transfers with random grant
    for (int it = 0; it < 8; it++) begin
      s  = $urandom & 32'hFFFFFFFC;
      ds = $urandom & 32'hFFFFFFFC;
      n  = $urandom_range(1, 5);
      ie = 1'($urandom_range(0, 1));
      start_xfer(s, ds, n, {30'd0, ie, 1'b1});
      wait_idle($sformatf("rnd%0d_wait", it), 300, 1'b1);
      check_writes($sformatf("rnd%0d", it), s, ds, int'(n));
      cfg_read(32'h0, d);
      check($sformatf("rnd%0d_ctrl", it), d, {29'd0, 1'b1, ie, 1'b0});
      check($sformatf("rnd%0d_int", it), 32'(dma_int_flag_o), 32'(ie));
      cfg_write(32'h0, 32'h0);
    end

    // Reset in the middle of a transfer
    m_gnt_i = 1'b1;
    start_xfer(32'hA00, 32'hB00, 32'd5, 32'h3);
    wait_writes("rst_mid_w1", 1, 20);
    base  = wq_addr.size();
    rst_n = 1'b0;
    #1;
    check("rst_mid_wr_en", 32'(m_wr_en_o), 32'h0);
    check("rst_mid_req", 32'(m_req_o), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("rst_mid_no_writes", 32'(wq_addr.size()), 32'(base));
    cfg_read(32'h0, d);
    check("rst_mid_ctrl", d, 32'h0);
    cfg_read(32'h4, d);
    check("rst_mid_src", d, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
